// File: rtl/idex_skid_stage.sv
`default_nettype none
// ============================================================================
// Module      : idex_skid_stage
// Description : ID/EX pipeline register with a two-entry skid buffer.
//               The main register drives the EX-side outputs. The skid
//               register absorbs one entry when EX back-pressures. i_ready
//               is registered, so there is no combinational path from
//               o_ready back to the ID side.
// Revision    : 1.0 - initial release
// ============================================================================
module idex_skid_stage #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 4,
    parameter int CNT_W   = 8,
    parameter int PASS_EN = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic [2:0]            i_ctrl,
    input  logic [ADDR_W-1:0]     i_wa,
    input  logic [2*DATA_W-1:0]   i_ops,
    input  logic [3*DATA_W-1:0]   i_mem,
    input  logic [DATA_W-1:0]     i_pc,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic [2:0]            o_ctrl,
    output logic [ADDR_W-1:0]     o_wa,
    output logic [2*DATA_W-1:0]   o_ops,
    output logic [3*DATA_W-1:0]   o_mem,
    output logic [DATA_W-1:0]     o_pc,
    output logic [1:0]            o_occ,
    output logic [CNT_W-1:0]      o_stall_cnt
);

    // Non-control payload, packed as {wa, ops, mem, pc}
    localparam int               C_MW       = ADDR_W + 6*DATA_W;
    localparam logic [CNT_W-1:0] C_CNT_MAX  = {CNT_W{1'b1}};

    logic              w_accept;
    logic              w_release;
    logic [C_MW-1:0]   w_in_data;

    logic              main_valid_q, main_valid_d;
    logic              skid_valid_q, skid_valid_d;
    logic              rdy_q,        rdy_d;
    logic [2:0]        ctrl_q,       ctrl_d;
    logic [C_MW-1:0]   data_q,       data_d;
    logic [2:0]        skid_ctrl_q,  skid_ctrl_d;
    logic [C_MW-1:0]   skid_data_q,  skid_data_d;
    logic [CNT_W-1:0]  stall_q,      stall_d;

    assign w_in_data = {i_wa, i_ops, i_mem, i_pc};
    assign w_accept  = i_valid && rdy_q;
    assign w_release = main_valid_q && o_ready;

    // The reserved empty-stage mode behaves exactly like the registered mode
    generate
        if (PASS_EN == 0) begin : g_pass_reserved
            assign i_ready = rdy_q;
        end else begin : g_pass_registered
            assign i_ready = rdy_q;
        end
    endgenerate

    // Next-state selection for main/skid occupancy and payload movement
    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        ctrl_d       = ctrl_q;
        data_d       = data_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_data_d  = skid_data_q;

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (w_release && skid_valid_q) begin
            // Skid drains into main; i_ready is low so nothing is accepted
            main_valid_d = 1'b1;
            skid_valid_d = 1'b0;
            ctrl_d       = skid_ctrl_q;
            data_d       = skid_data_q;
        end else if (w_release || !main_valid_q) begin
            // Main is free this cycle: the incoming entry (if any) lands there
            main_valid_d = w_accept;
            if (w_accept) begin
                ctrl_d = i_ctrl;
                data_d = w_in_data;
            end
        end else if (w_accept) begin
            // Main is stuck, park the new entry in the skid register
            skid_valid_d = 1'b1;
            skid_ctrl_d  = i_ctrl;
            skid_data_d  = w_in_data;
        end

        // Control becomes a bubble whenever main is empty; data fields hold
        if (!main_valid_d) begin
            ctrl_d = 3'b000;
        end

        rdy_d = !skid_valid_d;
    end

    // Saturating count of cycles where EX back-pressures a valid entry
    always_comb begin
        stall_d = stall_q;
        if (main_valid_q && !o_ready && (stall_q != C_CNT_MAX)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    // Pipeline and skid state registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            rdy_q        <= 1'b1;
            ctrl_q       <= 3'b000;
            data_q       <= '0;
            skid_ctrl_q  <= 3'b000;
            skid_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            rdy_q        <= rdy_d;
            ctrl_q       <= ctrl_d;
            data_q       <= data_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_data_q  <= skid_data_d;
        end
    end

    // Stall counter register; flush intentionally has no effect here
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign o_valid     = main_valid_q;
    assign o_ctrl      = ctrl_q;
    assign {o_wa, o_ops, o_mem, o_pc} = data_q;
    assign o_occ       = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
    assign o_stall_cnt = stall_q;

endmodule
`default_nettype wire
